pipe_ctrl_gen: RTL and testbench

- Parametrised pipeline hazard controller for the RV32I core.
- Generalises the fixed 6-stage stall/flush controller in three ways:
  - N stall-request sources, each with a per-source stall depth.
  - M flushable front-end stages, with sticky flush held until each stage acknowledges.
  - Saturating performance counters, a flush-timeout watchdog and an encoded status state.
- Sits beside the pipeline; drives stage-enable holds and bubble-insert flushes.

---
 rtl/pipe_ctrl_gen_pkg.sv | 7 +
 rtl/sat_counter.sv | 17 +
 rtl/pipe_ctrl_gen.sv | 68 ++++++
 tb/tb_pipe_ctrl_gen.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_gen_pkg.sv
// pipe_ctrl_gen_pkg: shared state encodings and constants for the pipeline hazard controller
package pipe_ctrl_gen_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH, ST_HALT} state_t;
  localparam logic StallEnable = 1'b1;
  localparam logic FlushEnable = 1'b1;
  localparam int PipelineDepth = 6;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at MAX; sync clear, async active-low reset
//   clk, rst (active-low async), inc (count enable), clr (sync clear, wins over inc), q (count)
module sat_counter #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && q != MAX) q <= q + 1'b1;
endmodule

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: parametrised stall/flush hazard controller with counters and flush watchdog
//   clk, rst (async active-low), rdy (global ready), stallreq (per-source stall request),
//   jmp_enable (redirect, arms flush), flushed (per-stage flush ack),
//   stall (per-stage hold), flush (per-stage flush), state (RUN/STALL/FLUSH/HALT, registered),
//   stall_cycles / flush_count (saturating counters), flush_err (sticky watchdog error)
module pipe_ctrl_gen
  import pipe_ctrl_gen_pkg::*;
#(
  parameter int STAGES = PipelineDepth,
  parameter int NREQ = 2,
  parameter logic [NREQ*8-1:0] STALL_LVL = {8'd4, 8'd1},
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [NREQ-1:0]         stallreq,
  input  logic                    jmp_enable,
  input  logic [FLUSH_STAGES-1:0] flushed,
  output logic [STAGES-1:0]       stall,
  output logic [FLUSH_STAGES-1:0] flush,
  output logic [1:0]              state,
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        flush_count,
  output logic                    flush_err
);
  localparam int AW = $clog2(TIMEOUT + 1);
  logic [NREQ:0][STAGES-1:0] acc;
  logic [FLUSH_STAGES-1:0] pend;
  logic [AW-1:0] age;
  logic age_hit, err_q;
  state_t state_q, state_d;
  assign acc[0] = '0;
  for (genvar i = 0; i < NREQ; i++) begin : g_src
    // STALL_LVL lists sources MSB-first, so source 0 lives in the top byte
    localparam int L = int'(STALL_LVL[8*(NREQ-1-i) +: 8]);
    localparam logic [STAGES-1:0] M = {STAGES{1'b1}} >> (STAGES - 1 - L);
    assign acc[i+1] = acc[i] | (stallreq[i] ? M : '0);
  end
  assign stall = rdy ? acc[NREQ] : {STAGES{StallEnable}};
  // an ack only retires a flush while the pipe moves; a new redirect always wins
  assign flush = {FLUSH_STAGES{jmp_enable}} | (pend & ~(flushed & {FLUSH_STAGES{rdy}}));
  always_ff @(posedge clk or negedge rst)
    if (!rst) pend <= '0;
    else if (rdy) pend <= jmp_enable ? {FLUSH_STAGES{FlushEnable}} : pend & ~flushed;
  always_comb
    state_d = !rdy ? ST_HALT : |flush ? ST_FLUSH : |stall ? ST_STALL : ST_RUN;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= ST_RUN;
    else state_q <= state_d;
  assign state = state_q;
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(rdy && |stall), .clr(1'b0), .q(stall_cycles)
  );
  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(jmp_enable), .clr(1'b0), .q(flush_count)
  );
  sat_counter #(.WIDTH(AW), .MAX(AW'(TIMEOUT))) u_age (
    .clk(clk), .rst(rst), .inc(rdy && |pend), .clr(!(|pend) || (jmp_enable && rdy)), .q(age)
  );
  assign age_hit = age == AW'(TIMEOUT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) err_q <= 1'b0;
    else err_q <= err_q | age_hit;
  assign flush_err = err_q | age_hit;
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb_pipe_ctrl_gen: randomized and directed checks of pipe_ctrl_gen against a behavioural model
module tb_pipe_ctrl_gen;
  localparam int TIMEOUT = 64;
  localparam int CMAX = 65535;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic [1:0] stallreq = '0;
  logic jmp_enable = 1'b0;
  logic [1:0] flushed = '0;
  logic [5:0] stall;
  logic [1:0] flush;
  logic [1:0] state;
  logic [15:0] stall_cycles, flush_count;
  logic flush_err;
  int n_chk = 0;
  int n_fail = 0;
  int lvl [2] = '{4, 1};
  int m_pend [2];
  int m_age, m_sc, m_fc, m_state;
  bit m_err;

  pipe_ctrl_gen dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stallreq(stallreq), .jmp_enable(jmp_enable),
    .flushed(flushed), .stall(stall), .flush(flush), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count), .flush_err(flush_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // model: outputs derived from the rules; inputs are stable from negedge until the next posedge
  always @(negedge clk) begin
    int es, ef, hit;
    if (!rst) begin
      m_pend = '{0, 0};
      m_age = 0; m_sc = 0; m_fc = 0; m_state = 0; m_err = 0;
    end
    es = 0;
    if (!rdy) es = 63;
    else for (int i = 0; i < 2; i++) if (stallreq[i]) es |= (1 << (lvl[i] + 1)) - 1;
    ef = 0;
    for (int k = 0; k < 2; k++)
      if (jmp_enable || (m_pend[k] != 0 && !(flushed[k] && rdy))) ef |= 1 << k;
    hit = (m_age == TIMEOUT) ? 1 : 0;
    chk("m_stall", 16'(stall), 16'(es));
    chk("m_flush", 16'(flush), 16'(ef));
    chk("m_state", 16'(state), 16'(m_state));
    chk("m_stall_cycles", stall_cycles, 16'(m_sc));
    chk("m_flush_count", flush_count, 16'(m_fc));
    chk("m_flush_err", 16'(flush_err), 16'(m_err || hit != 0));
    if (rst) begin
      m_state = !rdy ? 3 : ef != 0 ? 2 : es != 0 ? 1 : 0;
      if (rdy && es != 0 && m_sc < CMAX) m_sc++;
      if (jmp_enable && m_fc < CMAX) m_fc++;
      m_err = m_err || hit != 0;
      if (m_pend[0] + m_pend[1] == 0 || (jmp_enable && rdy)) m_age = 0;
      else if (rdy && m_age < TIMEOUT) m_age++;
      if (rdy)
        for (int k = 0; k < 2; k++) m_pend[k] = jmp_enable ? 1 : (flushed[k] ? 0 : m_pend[k]);
    end
  end

  task automatic stepc(input logic r, input logic rd, input logic [1:0] rq, input logic j,
                       input logic [1:0] f);
    @(posedge clk);
    #1;
    rst = r; rdy = rd; stallreq = rq; jmp_enable = j; flushed = f;
    @(negedge clk);
  endtask

  initial begin
    stepc(1, 1, 2'b00, 1, 2'b00);
    stepc(1, 1, 2'b00, 0, 2'b00);
    repeat (3) stepc(0, 1, 2'b00, 0, 2'b00);
    chk("reset_flush", 16'(flush), 16'h0);
    chk("reset_count", flush_count, 16'h0);
    stepc(1, 1, 2'b00, 0, 2'b00);
    chk("idle_state", 16'(state), 16'h0);
    chk("idle_flush", 16'(flush), 16'h0);
    chk("idle_stall_cycles", stall_cycles, 16'h0);
    chk("idle_err", 16'(flush_err), 16'h0);
    stepc(1, 1, 2'b01, 0, 2'b00);
    chk("stall_src0", 16'(stall), 16'h1f);
    stepc(1, 1, 2'b10, 0, 2'b00);
    chk("stall_src1", 16'(stall), 16'h03);
    stepc(1, 1, 2'b11, 0, 2'b00);
    chk("stall_both", 16'(stall), 16'h1f);
    stepc(1, 0, 2'b00, 0, 2'b00);
    chk("stall_halt", 16'(stall), 16'h3f);
    stepc(1, 1, 2'b00, 0, 2'b00);
    chk("state_halt", 16'(state), 16'h3);
    stepc(1, 1, 2'b00, 1, 2'b00);
    chk("jmp_flush", 16'(flush), 16'h3);
    stepc(1, 1, 2'b00, 0, 2'b00);
    chk("jmp_held", 16'(flush), 16'h3);
    chk("jmp_count", flush_count, 16'h1);
    stepc(1, 1, 2'b00, 0, 2'b01);
    chk("ack0", 16'(flush), 16'h2);
    stepc(1, 1, 2'b00, 0, 2'b10);
    chk("ack1", 16'(flush), 16'h0);
    stepc(1, 1, 2'b00, 1, 2'b11);
    chk("collide_now", 16'(flush), 16'h3);
    stepc(1, 1, 2'b00, 0, 2'b00);
    chk("collide_rearm", 16'(flush), 16'h3);
    stepc(1, 1, 2'b00, 0, 2'b11);
    chk("collide_ack", 16'(flush), 16'h0);
    stepc(0, 1, 2'b00, 0, 2'b00);
    stepc(1, 1, 2'b00, 1, 2'b00);
    repeat (TIMEOUT) stepc(1, 1, 2'b00, 0, 2'b00);
    chk("wdog_before", 16'(flush_err), 16'h0);
    stepc(1, 1, 2'b00, 0, 2'b00);
    chk("wdog_hit", 16'(flush_err), 16'h1);
    stepc(1, 1, 2'b00, 0, 2'b11);
    stepc(1, 1, 2'b00, 0, 2'b00);
    chk("wdog_sticky", 16'(flush_err), 16'h1);
    stepc(0, 1, 2'b00, 0, 2'b00);
    chk("wdog_reset", 16'(flush_err), 16'h0);
    stepc(1, 1, 2'b00, 0, 2'b00);
    repeat (10) stepc(1, 1, 2'b01, 0, 2'b00);
    repeat (5) stepc(1, 0, 2'b01, 0, 2'b00);
    chk("rdy_not_counted", stall_cycles, 16'd10);
    repeat (70000) stepc(1, 1, 2'b01, 0, 2'b00);
    chk("stall_sat", stall_cycles, 16'hffff);
    repeat (3000)
      stepc($urandom_range(199) != 0, $urandom_range(7) != 0, 2'($urandom),
            $urandom_range(9) == 0, 2'($urandom) & 2'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
